// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C target: FSM state
//            encoding, target address, accelerometer register map and a
//            majority-vote helper used by the optional line glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    // Target FSM states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    // 7-bit bus address of the accelerometer (0xA6 write / 0xA7 read on wire)
    localparam logic [6:0] I2C_ADDR_ADXL = 7'h53;

    // Register map used by the initiator's init/read sequences
    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;
    localparam logic [7:0] REG_DATAX1      = 8'h33;
    localparam logic [7:0] REG_DATAY0      = 8'h34;
    localparam logic [7:0] REG_DATAY1      = 8'h35;
    localparam logic [7:0] REG_DATAZ0      = 8'h36;
    localparam logic [7:0] REG_DATAZ1      = 8'h37;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// Module   : i2c_line_sync
// Purpose  : Brings one SCL/SDA pair into the clk domain (2-FF sync), an
//            optional 3-sample majority filter, then edge and START/STOP
//            detection. Edge/START/STOP outputs are combinational from the
//            conditioned levels so the consumer acts on the following edge.
//            Build option: I2C_TARGET_GLITCH_FILTER_EN enables the filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_flt;
    logic       sda_flt;
    logic       scl_prev;
    logic       sda_prev;

    // Two-flop synchronizers; reset to the idle (released, high) bus level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // Majority of the last three synchronized samples rejects 1-clk pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_flt  <= 1'b1;
            sda_flt  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_flt  <= i2c_pkg::maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
            sda_flt  <= i2c_pkg::maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_flt = scl_sync[1];
    assign sda_flt = sda_sync[1];
`endif

    // Previous conditioned levels for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_flt;
            sda_prev <= sda_flt;
        end
    end

    assign sda      = sda_flt;
    assign scl_rise = scl_flt & ~scl_prev;
    assign scl_fall = ~scl_flt & scl_prev;
    // SDA edges while SCL stays high are bus conditions, not data
    assign start    = scl_flt & scl_prev & sda_prev & ~sda_flt;
    assign stop     = scl_flt & scl_prev & ~sda_prev & sda_flt;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target with 7-bit address match. Write transfers load an
//            8-bit register pointer then issue reg_we strobes; read transfers
//            issue reg_re strobes and shift reg_rdata out on SDA. Pointer
//            auto-increments and wraps. SDA is driven open-drain via sda_oe.
//            Build option: I2C_TARGET_GLITCH_FILTER_EN (line glitch filter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = I2C_ADDR_ADXL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    state_t      state;
    state_t      state_nxt;
    logic        sda;
    logic        scl_rise;
    logic        scl_fall;
    logic        start;
    logic        stop;
    logic [6:0]  shift;     // bits received so far in the current byte
    logic [3:0]  bit_cnt;   // SCL rises seen in the current byte
    logic [7:0]  ptr;
    logic        rw;
    logic [6:0]  tx;        // remaining read bits, next bit in tx[6]
    logic        fetch_d;   // reg_re delayed: read data is valid this cycle
    logic [7:0]  byte_in;
    logic        last_bit;
    logic        addr_hit;

    i2c_line_sync u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign byte_in  = {shift, sda};
    assign last_bit = scl_rise && (bit_cnt == 4'd7);
    assign addr_hit = (byte_in[7:1] == ADDR);
    assign reg_addr = ptr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; START outranks STOP and any pending bit action.
    // In ACK states sda_oe marks the phase: low = waiting for the fall after
    // bit 8, high = waiting for the fall after bit 9.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ADDR;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:      if (last_bit) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK:  if (scl_fall && sda_oe) state_nxt = rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (last_bit) state_nxt = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall && sda_oe) state_nxt = ST_WDATA;
                ST_WDATA:     if (last_bit) state_nxt = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall && sda_oe) state_nxt = ST_WDATA;
                ST_RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda) state_nxt = ST_WAIT_STOP;
                    else if (scl_fall)   state_nxt = ST_RDATA;
                end
                default:      state_nxt = state;
            endcase
        end
    end

    // Datapath: shifting, pointer, strobes and open-drain SDA control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            tx        <= '0;
            fetch_d   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_wdata <= '0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            fetch_d <= reg_re;
            // Write strobe has been presented at the old pointer; advance now
            if (reg_we) ptr <= ptr + 8'd1;
            if (start) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                fetch_d <= 1'b0;
            end else if (stop) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                fetch_d <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit && addr_hit) begin
                                busy <= 1'b1;
                                rw   <= byte_in[0];
                            end
                        end
                    end
                    ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit) begin
                                if (state == ST_PTR) begin
                                    ptr <= byte_in;
                                end else begin
                                    reg_wdata <= byte_in;
                                    reg_we    <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ST_ADDR_ACK && rw) reg_re <= 1'b1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fetch_d) begin
                            // MSB goes out in the same SCL low phase as the fetch
                            tx     <= reg_rdata[6:0];
                            sda_oe <= ~reg_rdata[7];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;   // release for the initiator's ACK
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                        end else if (scl_fall) begin
                            reg_re  <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module   : tb_i2c_target
// Purpose  : Directed self-checking bench for i2c_target: reset state,
//            single write, multi-byte read with repeated START, wrong
//            address, STOP mid-byte, pointer wrap and async reset mid-ACK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;   // quarter of an SCL bit period, in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    wire        sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] rdata = 8'h00;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Register model and strobe logs
    logic [7:0] mem [256];
    logic [7:0] we_addr [16];
    logic [7:0] we_data [16];
    logic [7:0] re_addr [16];
    int         we_cnt = 0;
    int         re_cnt = 0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic       clr_logs = 1'b0;

    assign sda_line = sda_drv & ~sda_oe;

    always #10 clk = ~clk;

    i2c_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_drv),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (rdata),
        .busy      (busy)
    );

    // Register port model (read data one cycle after reg_re) and logging
    always @(posedge clk) begin
        if (reg_re) rdata <= mem[reg_addr];
        if (clr_logs) begin
            we_cnt    <= 0;
            re_cnt    <= 0;
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (sda_oe) oe_seen <= 1'b1;
            if (busy)   busy_seen <= 1'b1;
            if (reg_we && we_cnt < 16) begin
                we_addr[we_cnt] <= reg_addr;
                we_data[we_cnt] <= reg_wdata;
                we_cnt <= we_cnt + 1;
            end
            if (reg_re && re_cnt < 16) begin
                re_addr[re_cnt] <= reg_addr;
                re_cnt <= re_cnt + 1;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        clr_logs = 1'b1;
        wait_clks(1);
        clr_logs = 1'b0;
    endtask

    // Bus primitives: every one ends just after an SCL fall (or idle)
    task automatic i2c_start();
        wait_clks(Q); sda_drv = 1'b1;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(Q); sda_drv = 1'b0;
        wait_clks(Q); scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(Q); sda_drv = 1'b0;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(Q); sda_drv = 1'b1;
        wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clks(Q); sda_drv = b;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(2 * Q); scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] data, output logic acked);
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        wait_clks(Q); sda_drv = 1'b1;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(Q); acked = (sda_line == 1'b0);
        wait_clks(Q); scl_drv = 1'b0;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            wait_clks(Q); sda_drv = 1'b1;
            wait_clks(Q); scl_drv = 1'b1;
            wait_clks(Q); data[i] = sda_line;
            wait_clks(Q); scl_drv = 1'b0;
        end
        wait_clks(Q); sda_drv = ~ack;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(2 * Q); scl_drv = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(4);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); end
        checks++; if ({reg_we, reg_re, reg_wdata} !== 10'h000) begin failures++; $display("FAIL reset_strobes: got %h expected 000", {reg_we, reg_re, reg_wdata}); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        clear_logs();
        i2c_start();
        write_byte(8'hA6, a0);
        write_byte(8'h31, a1);
        write_byte(8'h0B, a2);
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL wr_acks: got %b expected 111", {a0, a1, a2}); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_before_stop: got %b expected 1", busy); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL wr_we_count: got %0d expected 1", we_cnt); end
        checks++; if ({we_addr[0], we_data[0]} !== 16'h310B) begin failures++; $display("FAIL wr_we_addr_data: got %h expected 310b", {we_addr[0], we_data[0]}); end
    endtask

    task automatic test_multi_read();
        logic [7:0] exp_data [6];
        logic [7:0] d;
        logic       a0, a1, a2;
        exp_data = '{8'h10, 8'h22, 8'hE5, 8'h7F, 8'h81, 8'hC3};
        for (int i = 0; i < 6; i++) mem[8'h32 + i] = exp_data[i];
        clear_logs();
        i2c_start();
        write_byte(8'hA6, a0);
        write_byte(8'h32, a1);
        i2c_start();
        write_byte(8'hA7, a2);
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rd_acks: got %b expected 111", {a0, a1, a2}); end
        for (int i = 0; i < 6; i++) begin
            read_byte(i < 5, d);
            checks++; if (d !== exp_data[i]) begin failures++; $display("FAIL rd_byte%0d: got %h expected %h", i, d, exp_data[i]); end
        end
        wait_clks(6);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rd_sda_oe_after_nack: got %b expected 0", sda_oe); end
        i2c_stop();
        checks++; if (re_cnt !== 6) begin failures++; $display("FAIL rd_re_count: got %0d expected 6", re_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (re_addr[i] !== 8'(8'h32 + i)) begin failures++; $display("FAIL rd_re_addr%0d: got %h expected %h", i, re_addr[i], 8'(8'h32 + i)); end
        end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL rd_no_we: got %0d expected 0", we_cnt); end
    endtask

    task automatic test_wrong_address();
        logic a0, a1;
        clear_logs();
        i2c_start();
        write_byte(8'hA4, a0);
        write_byte(8'h31, a1);
        i2c_stop();
        checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL wa_acks: got %b expected 00", {a0, a1}); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL wa_sda_oe_seen: got %b expected 0", oe_seen); end
        checks++; if ({we_cnt, re_cnt} !== {32'd0, 32'd0}) begin failures++; $display("FAIL wa_strobes: got we=%0d re=%0d expected 0 0", we_cnt, re_cnt); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL wa_busy_seen: got %b expected 0", busy_seen); end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2;
        logic [7:0] partial;
        partial = 8'h55;
        clear_logs();
        i2c_start();
        write_byte(8'hA6, a0);
        write_byte(8'h2C, a1);
        for (int i = 7; i >= 4; i--) write_bit(partial[i]);
        i2c_stop();
        wait_clks(4);
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL smb_state: got %0d expected %0d", dut.state, ST_IDLE); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL smb_no_we: got %0d expected 0", we_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL smb_busy: got %b expected 0", busy); end
        i2c_start();
        write_byte(8'hA6, a0);
        write_byte(8'h2D, a1);
        write_byte(8'h08, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL smb_next_acks: got %b expected 111", {a0, a1, a2}); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL smb_next_we_count: got %0d expected 1", we_cnt); end
        checks++; if ({we_addr[0], we_data[0]} !== 16'h2D08) begin failures++; $display("FAIL smb_next_we: got %h expected 2d08", {we_addr[0], we_data[0]}); end
    endtask

    task automatic test_ptr_wrap();
        logic a0, a1, a2, a3;
        clear_logs();
        i2c_start();
        write_byte(8'hA6, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL wrap_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        checks++; if (we_cnt !== 2) begin failures++; $display("FAIL wrap_we_count: got %0d expected 2", we_cnt); end
        checks++; if ({we_addr[0], we_data[0]} !== 16'hFF11) begin failures++; $display("FAIL wrap_we0: got %h expected ff11", {we_addr[0], we_data[0]}); end
        checks++; if ({we_addr[1], we_data[1]} !== 16'h0022) begin failures++; $display("FAIL wrap_we1: got %h expected 0022", {we_addr[1], we_data[1]}); end
        checks++; if (reg_addr !== 8'h01) begin failures++; $display("FAIL wrap_ptr_after: got %h expected 01", reg_addr); end
    endtask

    task automatic test_async_reset();
        logic [7:0] addr_byte;
        addr_byte = 8'hA6;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
        wait_clks(Q);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL ar_ack_driven: got %b expected 1", sda_oe); end
        #2 reset = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL ar_sda_oe_async: got %b expected 0", sda_oe); end
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL ar_state: got %0d expected %0d", dut.state, ST_IDLE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy: got %b expected 0", busy); end
        i2c_stop();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_single_write();
        test_multi_read();
        test_wrong_address();
        test_stop_mid_byte();
        test_ptr_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
